// File: rtl/memsync_xfer_ctrl.sv
// memsync_xfer_ctrl
// Queues MEMSync row-miss requests (fill, or writeback-then-fill) and plays
// them out to the backing-store port one at a time, in arrival order.
// Each request issues one or two row commands, counts BEATS data beats per
// command, and ends with a one-cycle sync pulse that releases the MEMSync stall.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake (ready = FIFO not full)
//   req_wb              1: write back req_wbrow then fill req_row; 0: fill only
//   req_row, req_wbrow  backing-store rows; req_crow cache slot for both
//   mem_cmd_*           row command to the backing store (valid/ready)
//   mem_beat            one data beat completed this cycle
//   mem_beat_idx        index of the next expected beat
//   sync                request fully complete (one cycle)
//   busy                a request is in progress
//   pending             FIFO occupancy
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting; pops the FIFO head when one is present
// WB_CMD    | presenting the writeback command (victim row)
// WB_DATA   | counting writeback beats
// FILL_CMD  | presenting the fill command
// FILL_DATA | counting fill beats
// DONE      | sync pulse, back to IDLE

module memsync_xfer_ctrl #(
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int BEATS     = 16,
    parameter int QDEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_wb,
    input  logic [ADDRWIDTH-1:0]         req_row,
    input  logic [ADDRWIDTH-1:0]         req_wbrow,
    input  logic [CHWIDTH-1:0]           req_crow,
    output logic                         mem_cmd_valid,
    input  logic                         mem_cmd_ready,
    output logic                         mem_cmd_wr,
    output logic [ADDRWIDTH-1:0]         mem_cmd_row,
    output logic [CHWIDTH-1:0]           mem_cmd_crow,
    input  logic                         mem_beat,
    output logic [$clog2(BEATS)-1:0]     mem_beat_idx,
    output logic                         sync,
    output logic                         busy,
    output logic [$clog2(QDEPTH):0]      pending
);

    localparam int BW = $clog2(BEATS);
    localparam int QW = $clog2(QDEPTH);
    localparam int EW = 1 + 2 * ADDRWIDTH + CHWIDTH;
    localparam logic [QW:0]   Q_FULL    = (QW + 1)'(QDEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_CMD,
        S_WB_DATA,
        S_FILL_CMD,
        S_FILL_DATA,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // request FIFO
    logic [EW-1:0]        fifo_mem [QDEPTH];
    logic [QW-1:0]        wr_ptr, rd_ptr;
    logic [QW:0]          count;
    logic                 full, empty, push, pop;

    logic                 head_wb;
    logic [ADDRWIDTH-1:0] head_row, head_wbrow;
    logic [CHWIDTH-1:0]   head_crow;

    // request being played out
    logic [ADDRWIDTH-1:0] cur_row, cur_wbrow;
    logic [CHWIDTH-1:0]   cur_crow;

    logic [BW-1:0]        beat_cnt;
    logic                 data_phase, last_beat, cmd_hs;

    assign full      = (count == Q_FULL);
    assign empty     = (count == '0);
    // ready looks at full only, so a pop in the same cycle never frees a slot early
    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign pending   = count;

    assign {head_wb, head_row, head_wbrow, head_crow} = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_wb, req_row, req_wbrow, req_crow};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_row   <= '0;
            cur_wbrow <= '0;
            cur_crow  <= '0;
        end else if (pop) begin
            cur_row   <= head_row;
            cur_wbrow <= head_wbrow;
            cur_crow  <= head_crow;
        end
    end

    // beat counter: cleared on every command handshake, wraps after the last beat
    assign data_phase   = (state == S_WB_DATA) || (state == S_FILL_DATA);
    assign last_beat    = (beat_cnt == LAST_BEAT);
    assign cmd_hs       = mem_cmd_valid & mem_cmd_ready;
    assign mem_beat_idx = beat_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (cmd_hs) begin
            beat_cnt <= '0;
        end else if (data_phase && mem_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_wr    = 1'b0;
        mem_cmd_row   = '0;
        mem_cmd_crow  = '0;
        sync          = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = head_wb ? S_WB_CMD : S_FILL_CMD;
                end
            end
            S_WB_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_wr    = 1'b1;
                mem_cmd_row   = cur_wbrow;
                mem_cmd_crow  = cur_crow;
                if (mem_cmd_ready) begin
                    state_nxt = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                if (mem_beat && last_beat) begin
                    state_nxt = S_FILL_CMD;
                end
            end
            S_FILL_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_row   = cur_row;
                mem_cmd_crow  = cur_crow;
                if (mem_cmd_ready) begin
                    state_nxt = S_FILL_DATA;
                end
            end
            S_FILL_DATA: begin
                if (mem_beat && last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                sync      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memsync_xfer_ctrl.sv
// Self-checking bench for memsync_xfer_ctrl: directed timing scenarios with
// cycle numbers counted from the request-accept cycle, plus a randomized run
// checked cycle by cycle against a queue-based transaction model.

module tb_memsync_xfer_ctrl;

    localparam int CW = 6;
    localparam int AW = 17;
    localparam int BT = 16;
    localparam int QD = 4;
    localparam int BW = $clog2(BT);
    localparam int PW = $clog2(QD) + 1;

    typedef struct packed {
        logic          wb;
        logic [AW-1:0] row;
        logic [AW-1:0] wbrow;
        logic [CW-1:0] crow;
    } req_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] row;
        logic [CW-1:0] crow;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wb;
    logic [AW-1:0] req_row, req_wbrow;
    logic [CW-1:0] req_crow;
    logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
    logic [AW-1:0] mem_cmd_row;
    logic [CW-1:0] mem_cmd_crow;
    logic          mem_beat;
    logic [BW-1:0] mem_beat_idx;
    logic          sync, busy;
    logic [PW-1:0] pending;

    int tests = 0;
    int fails = 0;

    memsync_xfer_ctrl #(.CHWIDTH(CW), .ADDRWIDTH(AW), .BEATS(BT), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_row(req_row), .req_wbrow(req_wbrow), .req_crow(req_crow),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_wr(mem_cmd_wr), .mem_cmd_row(mem_cmd_row), .mem_cmd_crow(mem_cmd_crow),
        .mem_beat(mem_beat), .mem_beat_idx(mem_beat_idx),
        .sync(sync), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // leaves the bench in "cycle 0": DUT idle, FIFO empty, rst low
    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_wb = 1'b0; req_row = '0; req_wbrow = '0; req_crow = '0;
        mem_cmd_ready = 1'b0; mem_beat = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        req_valid = 1'b1; mem_beat = 1'b1; mem_cmd_ready = 1'b1;
        tick();
        tests++;
        if ({req_ready, mem_cmd_valid, mem_cmd_wr, sync, busy} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, mem_cmd_valid, mem_cmd_wr, sync, busy});
        end
        tests++;
        if ({mem_cmd_row, mem_cmd_crow, mem_beat_idx, pending} !== '0) begin
            fails++;
            $display("FAIL reset_data: row %h crow %h idx %h pending %h expected all 0",
                     mem_cmd_row, mem_cmd_crow, mem_beat_idx, pending);
        end
        rst = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_single_fill();
        int sync_at, nsync;
        do_reset();
        mem_cmd_ready = 1'b1; mem_beat = 1'b1;
        req_valid = 1'b1; req_wb = 1'b0; req_row = 17'h1A2B3; req_crow = 6'd5;
        tick();
        req_valid = 1'b0;
        tests++;
        if (pending !== 3'd1 || mem_cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL fill_cycle1: pending %0d valid %b expected 1 0", pending, mem_cmd_valid);
        end
        tick();
        tests++;
        if ({mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow} !== {1'b1, 1'b0, 17'h1A2B3, 6'd5}) begin
            fails++;
            $display("FAIL fill_cmd: valid %b wr %b row %h crow %0d expected 1 0 1a2b3 5",
                     mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow);
        end
        sync_at = -1; nsync = 0;
        for (int c = 3; c <= 40; c++) begin
            tick();
            if (sync) begin
                nsync++;
                if (sync_at < 0) sync_at = c;
            end
        end
        tests++;
        if (sync_at != 19 || nsync != 1) begin
            fails++;
            $display("FAIL fill_sync: cycle %0d count %0d expected 19 1", sync_at, nsync);
        end
        tests++;
        if (pending !== 3'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL fill_end: pending %0d busy %b expected 0 0", pending, busy);
        end
    endtask

    task automatic test_wb_fill();
        int sync_at, fill_at;
        logic [AW-1:0] fill_row;
        do_reset();
        mem_cmd_ready = 1'b1; mem_beat = 1'b1;
        req_valid = 1'b1; req_wb = 1'b1; req_row = 17'h1FFFF; req_wbrow = 17'h00042; req_crow = 6'd63;
        tick();
        req_valid = 1'b0; req_wb = 1'b0;
        tick();
        tests++;
        if ({mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow} !== {1'b1, 1'b1, 17'h00042, 6'd63}) begin
            fails++;
            $display("FAIL wb_cmd: valid %b wr %b row %h crow %0d expected 1 1 00042 63",
                     mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow);
        end
        sync_at = -1; fill_at = -1; fill_row = '0;
        for (int c = 3; c <= 50; c++) begin
            tick();
            if (mem_cmd_valid && !mem_cmd_wr && fill_at < 0) begin
                fill_at = c;
                fill_row = mem_cmd_row;
            end
            if (sync && sync_at < 0) sync_at = c;
        end
        tests++;
        if (fill_at != 19 || fill_row !== 17'h1FFFF) begin
            fail_wbfill(fill_at, fill_row);
        end
        tests++;
        if (sync_at != 36) begin
            fails++;
            $display("FAIL wb_sync: cycle %0d expected 36", sync_at);
        end
    endtask

    task automatic fail_wbfill(input int at, input logic [AW-1:0] row);
        fails++;
        $display("FAIL wb_fill_cmd: cycle %0d row %h expected 19 1ffff", at, row);
    endtask

    task automatic test_stall();
        int sync_at, nb;
        do_reset();
        req_valid = 1'b1; req_wb = 1'b0; req_row = 17'h0BEEF; req_crow = 6'd9;
        sync_at = -1; nb = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            req_valid = 1'b0;
            mem_cmd_ready = (c >= 7);
            mem_beat = (c % 2 == 1);
            if (c >= 2 && c <= 6) begin
                tests++;
                if ({mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow} !== {1'b1, 1'b0, 17'h0BEEF, 6'd9}) begin
                    fails++;
                    $display("FAIL stall_hold c%0d: valid %b wr %b row %h crow %0d expected 1 0 0beef 9",
                             c, mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow);
                end
            end
            if (c >= 8 && c <= 40) begin
                tests++;
                if (mem_beat_idx !== BW'(nb % BT)) begin
                    fails++;
                    $display("FAIL stall_idx c%0d: got %0d expected %0d", c, mem_beat_idx, nb % BT);
                end
                if (mem_beat) nb++;
            end
            if (sync && sync_at < 0) sync_at = c;
        end
        tests++;
        if (sync_at != 40) begin
            fails++;
            $display("FAIL stall_sync: cycle %0d expected 40", sync_at);
        end
    endtask

    task automatic test_fifo_full();
        int p, nsync;
        logic [CW-1:0] got[$];
        do_reset();
        p = 0; nsync = 0;
        for (int c = 0; c < 600; c++) begin
            req_valid = (p < 6);
            req_wb = p[0];
            req_row = AW'(100 + p);
            req_wbrow = AW'(200 + p);
            req_crow = CW'(10 + p);
            mem_cmd_ready = (c >= 20);
            mem_beat = (c >= 20);
            if (c == 5 || c == 19) begin
                tests++;
                if (pending !== 3'd4 || req_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL full_c%0d: pending %0d ready %b expected 4 0", c, pending, req_ready);
                end
            end
            if (mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr) got.push_back(mem_cmd_crow);
            if (sync) nsync++;
            if (req_valid && req_ready) p++;
            if (nsync == 6 && p == 6) break;
            tick();
        end
        req_valid = 1'b0;
        tests++;
        if (nsync != 6 || got.size() != 6) begin
            fails++;
            $display("FAIL full_count: syncs %0d fills %0d expected 6 6", nsync, got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            tests++;
            if (got[i] !== CW'(10 + i)) begin
                fails++;
                $display("FAIL full_order[%0d]: crow %0d expected %0d", i, got[i], 10 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sync_at, nsync;
        do_reset();
        mem_cmd_ready = 1'b1; mem_beat = 1'b1;
        req_wb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1; req_row = AW'(c + 1); req_crow = CW'(20 + c);
            tick();
        end
        req_valid = 1'b0;
        repeat (7) tick();
        tests++;
        if (mem_beat_idx !== 4'd7 || pending !== 3'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rmid_pre: idx %0d pending %0d busy %b expected 7 2 1", mem_beat_idx, pending, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({req_ready, mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow, mem_beat_idx, sync, busy, pending}
            !== {1'b1, 1'b0, 1'b0, {AW{1'b0}}, {CW{1'b0}}, {BW{1'b0}}, 1'b0, 1'b0, {PW{1'b0}}}) begin
            fails++;
            $display("FAIL rmid_reset: ready %b valid %b wr %b row %h crow %h idx %0d sync %b busy %b pending %0d expected 1 0 0 0 0 0 0 0 0",
                     req_ready, mem_cmd_valid, mem_cmd_wr, mem_cmd_row, mem_cmd_crow, mem_beat_idx, sync, busy, pending);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (sync !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
                fails++;
                $display("FAIL rmid_quiet %0d: sync %b busy %b pending %0d expected 0 0 0", i, sync, busy, pending);
            end
        end
        req_valid = 1'b1; req_row = 17'h00777; req_crow = 6'd33;
        sync_at = -1; nsync = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            req_valid = 1'b0;
            if (sync) begin
                nsync++;
                if (sync_at < 0) sync_at = c;
            end
        end
        tests++;
        if (sync_at != 19 || nsync != 1) begin
            fails++;
            $display("FAIL rmid_after: sync cycle %0d count %0d expected 19 1", sync_at, nsync);
        end
    endtask

    task automatic test_stray_beats();
        int sync_at, nsync;
        do_reset();
        mem_beat = 1'b1; mem_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (mem_beat_idx !== 4'd0 || busy !== 1'b0 || sync !== 1'b0) begin
                fails++;
                $display("FAIL stray_idle %0d: idx %0d busy %b sync %b expected 0 0 0", i, mem_beat_idx, busy, sync);
            end
        end
        req_valid = 1'b1; req_wb = 1'b0; req_row = 17'h10101; req_crow = 6'd7;
        sync_at = -1; nsync = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            req_valid = 1'b0;
            mem_cmd_ready = (c >= 6);
            mem_beat = (c < 6) || (c >= 10);
            if (c <= 10) begin
                tests++;
                if (mem_beat_idx !== 4'd0 || sync !== 1'b0) begin
                    fails++;
                    $display("FAIL stray_cmd c%0d: idx %0d sync %b expected 0 0", c, mem_beat_idx, sync);
                end
            end
            if (sync) begin
                nsync++;
                if (sync_at < 0) sync_at = c;
            end
        end
        tests++;
        if (sync_at != 26 || nsync != 1) begin
            fails++;
            $display("FAIL stray_sync: cycle %0d count %0d expected 26 1", sync_at, nsync);
        end
    endtask

    // Transaction model: a queue of accepted requests, a list of commands still
    // owed by the active request, and the number of beats seen in the current
    // data phase. A request becomes active in the first idle cycle after it is
    // queued; sync follows the last beat of the fill and lasts one cycle.
    task automatic test_random();
        req_t mq[$];
        cmd_t ops[$];
        req_t r;
        bit   m_active, m_in_data, m_done, exp_cv, push, draining, settled;
        int   m_beats;
        do_reset();
        m_active = 0; m_in_data = 0; m_done = 0; m_beats = 0; settled = 0;
        for (int c = 0; c < 6000; c++) begin
            draining = (c >= 4000);
            if (draining) begin
                req_valid = 1'b0; mem_cmd_ready = 1'b1; mem_beat = 1'b1;
            end else begin
                req_valid = ((c / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
                mem_cmd_ready = ($urandom_range(0, 3) != 0);
                mem_beat = ($urandom_range(0, 3) != 0);
            end
            req_wb = $urandom_range(0, 1);
            req_row = AW'($urandom);
            req_wbrow = AW'($urandom);
            req_crow = CW'($urandom);

            exp_cv = m_active && !m_in_data && !m_done && (ops.size() > 0);
            tests++;
            if (busy !== m_active || sync !== m_done || mem_cmd_valid !== exp_cv ||
                pending !== PW'(mq.size()) || req_ready !== (mq.size() < QD) ||
                mem_beat_idx !== BW'(m_in_data ? m_beats : 0)) begin
                fails++;
                $display("FAIL rnd_ctrl c%0d: busy %b sync %b valid %b pending %0d ready %b idx %0d expected %b %b %b %0d %b %0d",
                         c, busy, sync, mem_cmd_valid, pending, req_ready, mem_beat_idx,
                         m_active, m_done, exp_cv, mq.size(), mq.size() < QD, m_in_data ? m_beats : 0);
            end
            if (exp_cv) begin
                tests++;
                if ({mem_cmd_wr, mem_cmd_row, mem_cmd_crow} !== ops[0]) begin
                    fails++;
                    $display("FAIL rnd_cmd c%0d: got %h expected %h", c,
                             {mem_cmd_wr, mem_cmd_row, mem_cmd_crow}, ops[0]);
                end
            end

            push = req_valid && (mq.size() < QD);
            if (m_done) begin
                m_done = 0;
                m_active = 0;
            end else if (!m_active && mq.size() > 0) begin
                r = mq.pop_front();
                m_active = 1;
                if (r.wb) ops.push_back('{wr: 1'b1, row: r.wbrow, crow: r.crow});
                ops.push_back('{wr: 1'b0, row: r.row, crow: r.crow});
            end else if (exp_cv && mem_cmd_ready) begin
                void'(ops.pop_front());
                m_in_data = 1;
                m_beats = 0;
            end else if (m_in_data && mem_beat) begin
                m_beats++;
                if (m_beats == BT) begin
                    m_in_data = 0;
                    m_beats = 0;
                    if (ops.size() == 0) m_done = 1;
                end
            end
            if (push) mq.push_back('{wb: req_wb, row: req_row, wbrow: req_wbrow, crow: req_crow});

            if (draining && mq.size() == 0 && !m_active && !m_done) begin
                settled = 1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        tests++;
        if (!settled) begin
            fails++;
            $display("FAIL rnd_drain: model queue %0d active %b expected 0 0", mq.size(), m_active);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_wb = 1'b0; req_row = '0; req_wbrow = '0; req_crow = '0;
        mem_cmd_ready = 1'b0; mem_beat = 1'b0;
        test_reset();
        test_single_fill();
        test_wb_fill();
        test_stall();
        test_fifo_full();
        test_reset_mid();
        test_stray_beats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
